ldtu_gain_select: RTL and testbench
===================================

# ldtu_gain_select

Selects between the baseline-subtracted gain-10 and gain-1 sample streams and sits directly downstream of the baseline subtraction stage in the LiTe-DTU datapath. While gain-10 is below the saturation threshold, gain-10 samples are forwarded. When a gain-10 sample reaches the threshold, a window of gain-1 samples replaces gain-10 on the output. The window starts PRE samples before the saturating sample, which is made possible by a delay line. The output is a 13-bit word {gain flag, 12-bit data} for the downstream compression/encoding stage.

## Interface
- Nbits_12, 12, sample width
- PRE, 5, number of pre-saturation samples included in the window (1..7)
- CLK  in  1  LiTe-DTU clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- DATA_gain_01  in  12  baseline-subtracted gain-1 sample, synchronous to CLK
- DATA_gain_10  in  12  baseline-subtracted gain-10 sample, synchronous to CLK
- SATURATION_value  in  12  gain-10 saturation threshold (quasi-static)
- TIME_WINDOW  in  1  0: window W=8 samples; 1: W=16 samples
- forceG1  in  1  force gain-1 output on every sample
- forceG10  in  1  force gain-10 output on every sample
- DATA_gain_sel  out  13  bit 12 = gain flag (1 = gain-1, 0 = gain-10); bits 11:0 = selected sample
- win_active  out  1  registered copy of the current sample's gain-1 window selection
- SeuError  out  1  constant 0 (no TMR in this version)

## Operation
- Stage 0 registers capture DATA_gain_01 and DATA_gain_10 on every CLK edge.
- Two delay lines, one per gain, each have stages 0..PRE. The output tap is stage PRE.
- Detection is combinational on stage 0: det = (g10_stage0 >= SATURATION_value), unsigned compare. A threshold of 0 gives det = 1 on every sample.
- Window counter cnt is 4 bits, range 0..15.
  - When det=1: sel_g01 = 1 and cnt_next = W-1.
  - When det=0 and cnt≠0: sel_g01 = 1 and cnt_next = cnt-1.
  - When det=0 and cnt=0: sel_g01 = 0 and cnt stays 0.
- With a single saturating sample n, the output carries gain-1 for tap samples n-PRE .. n-PRE+W-1, which is exactly W samples. POST = W-PRE, so POST = 3 for W=8 and 11 for W=16 at PRE=5.
- Retrigger: any det while the window is active reloads cnt to W-1. The window extends to POST-1 samples after the last saturating sample. Windows never truncate.
- TIME_WINDOW is sampled only at load time. A change while cnt≠0 affects the next load only.
- Force modes:
  - forceG1=1 gives flag=1 and gain-1 data on every sample.
  - Otherwise forceG10=1 gives flag=0 and gain-10 data.
  - forceG1 has priority when both are set.
  - The counter keeps running under force, so the automatic window resumes consistently when force is released.
- Output register: DATA_gain_sel <= {sel, sel ? g01_tap : g10_tap}, where sel is sel_g01 after force override. win_active <= sel_g01 before force override.

## Timing
- Latency is PRE+1 CLK edges from stage-0 capture to DATA_gain_sel: 6 edges at PRE=5.
- Throughput is one sample per CLK. There is no stall and no handshake.
- Reset (asynchronous assert, synchronous-safe deassert by the system) clears:
  - all delay stages to 0
  - cnt to 0
  - DATA_gain_sel to 13'h0000
  - win_active to 0
- Reset asserted mid-window aborts the window. After release, the first PRE+1 outputs carry zero data with flag 0, unless a force input is set.
- Simultaneous det and cnt=1 resolves as a reload, with no gap in the window.
- SATURATION_value changes take effect on the next stage-0 compare. Intermediate values during a change are not supported.

## Test plan
- Reset/pipeline: hold rst for 3 cycles, then feed ramp g10 = 0,1,2…, g01 = 0x800+k, with SATURATION_value = 0xFFF and PRE=5.
  - DATA_gain_sel = 0x0000 during reset.
  - Sample k appears at edge k+6 with flag 0.
  - win_active stays 0.
- Single saturation, W=8: g10 = 0x100 except 0xFFF at sample 20; g01 = 0x040+k; threshold 0xF00.
  - Samples 15..22 are output as {1, 0x040+k}.
  - Sample 14 and sample 23 are output as {0, 0x100}.
- Single saturation, W=16: same stimulus with TIME_WINDOW=1.
  - Samples 15..30 are gain-1.
  - Sample 31 is gain-10.
- Retrigger: saturation at samples 20 and 25 with W=8.
  - Gain-1 covers samples 15..27 continuously, 13 samples.
  - Then gain-10 resumes.
- Force and priority:
  - forceG1=1 gives every output flag 1 with g01 data.
  - forceG1=1 and forceG10=1 gives flag 1.
  - forceG10=1 with saturation at sample 20 gives flag 0 throughout, while win_active is 1 for samples 15..22.
- Reset mid-window: saturation at sample 20, rst pulsed at the edge where sample 17 is output.
  - Output goes 0x0000 immediately, as reset is asynchronous.
  - After release, win_active=0 and gain-10 resumes after 6 zero outputs.

Source files
------------

// File: rtl/ldtu_gain_select.sv
// Gain selector for the LiTe-DTU datapath: forwards gain-10 samples until one saturates, then
// substitutes a W-sample gain-1 window that starts PRE samples before the saturating sample.
module ldtu_gain_select #(
  parameter int Nbits_12 = 12,
  parameter int PRE      = 5
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic [Nbits_12-1:0] DATA_gain_01,
  input  logic [Nbits_12-1:0] DATA_gain_10,
  input  logic [Nbits_12-1:0] SATURATION_value,
  input  logic                TIME_WINDOW,
  input  logic                forceG1,
  input  logic                forceG10,
  output logic [Nbits_12:0]   DATA_gain_sel,
  output logic                win_active,
  output logic                SeuError
);

  logic [Nbits_12-1:0] r_g01Dly [PRE+1];
  logic [Nbits_12-1:0] r_g10Dly [PRE+1];
  logic [3:0]          r_cnt;

  logic                w_det;
  logic                w_selG01;
  logic                w_sel;
  logic [3:0]          w_cntNext;
  logic [Nbits_12-1:0] w_g01Tap;
  logic [Nbits_12-1:0] w_g10Tap;

  // Detection looks at stage 0 while the output taps stage PRE, which is what lets the
  // window open PRE samples ahead of the saturating sample.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= PRE; i++) begin
        r_g01Dly[i] <= '0;
        r_g10Dly[i] <= '0;
      end
    end else begin
      r_g01Dly[0] <= DATA_gain_01;
      r_g10Dly[0] <= DATA_gain_10;
      for (int i = 1; i <= PRE; i++) begin
        r_g01Dly[i] <= r_g01Dly[i-1];
        r_g10Dly[i] <= r_g10Dly[i-1];
      end
    end
  end

  assign w_det    = (r_g10Dly[0] >= SATURATION_value);
  assign w_g01Tap = r_g01Dly[PRE];
  assign w_g10Tap = r_g10Dly[PRE];

  // A detection always reloads, so a retrigger on the last window sample leaves no gap.
  always_comb begin
    w_selG01  = 1'b0;
    w_cntNext = r_cnt;
    if (w_det) begin
      w_selG01  = 1'b1;
      w_cntNext = TIME_WINDOW ? 4'd15 : 4'd7;
    end else if (r_cnt != 4'd0) begin
      w_selG01  = 1'b1;
      w_cntNext = r_cnt - 4'd1;
    end
    w_sel = forceG1 | (~forceG10 & w_selG01);
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_cnt         <= 4'd0;
      DATA_gain_sel <= '0;
      win_active    <= 1'b0;
    end else begin
      r_cnt         <= w_cntNext;
      DATA_gain_sel <= {w_sel, (w_sel ? w_g01Tap : w_g10Tap)};
      win_active    <= w_selG01;
    end
  end

  assign SeuError = 1'b0;

endmodule

// File: tb/tb_ldtu_gain_select.sv
// Bench for ldtu_gain_select: directed scenarios with literal expectations, then random traffic,
// all outputs compared every cycle against an edge-history model of the selection rules.
module tb_ldtu_gain_select;

  localparam int PRE    = 5;
  localparam int NEDGES = 4096;

  logic        CLK = 1'b0;
  logic        rst;
  logic [11:0] DATA_gain_01;
  logic [11:0] DATA_gain_10;
  logic [11:0] SATURATION_value;
  logic        TIME_WINDOW;
  logic        forceG1;
  logic        forceG10;
  logic [12:0] DATA_gain_sel;
  logic        win_active;
  logic        SeuError;

  int nChecks = 0;
  int nPass   = 0;

  // Model state: what stage 0 held after each edge, plus the latest reset and detection.
  int          t = 0;
  int          lastReset = 0;
  int          lastDet = -1;
  int          lastW = 8;
  int          tapIdx;
  logic [11:0] recG01 [NEDGES];
  logic [11:0] recG10 [NEDGES];
  logic [12:0] outLog [NEDGES];
  logic        winLog [NEDGES];
  logic        mSel;
  logic        mFlag;
  logic [11:0] mTap01;
  logic [11:0] mTap10;
  logic [12:0] expOut;
  logic        expWin;

  ldtu_gain_select #(.Nbits_12(12), .PRE(PRE)) dut (
    .CLK              (CLK),
    .rst              (rst),
    .DATA_gain_01     (DATA_gain_01),
    .DATA_gain_10     (DATA_gain_10),
    .SATURATION_value (SATURATION_value),
    .TIME_WINDOW      (TIME_WINDOW),
    .forceG1          (forceG1),
    .forceG10         (forceG10),
    .DATA_gain_sel    (DATA_gain_sel),
    .win_active       (win_active),
    .SeuError         (SeuError)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, t);
    else
      nPass++;
  endtask

  // Output after edge u is gain-1 when the most recent detection d (sample in stage 0 after
  // edge d, no reset since) satisfies u - d <= W chosen at that detection.
  always @(posedge CLK) begin
    t = t + 1;
    if (rst) begin
      lastReset = t;
      lastDet   = -1;
      recG01[t] = '0;
      recG10[t] = '0;
      expOut    = '0;
      expWin    = 1'b0;
    end else begin
      if (recG10[t-1] >= SATURATION_value) begin
        lastDet = t - 1;
        lastW   = TIME_WINDOW ? 16 : 8;
      end
      mSel   = (lastDet >= 0) && (t - lastDet <= lastW);
      tapIdx = t - 1 - PRE;
      mTap01 = (tapIdx >= lastReset) ? recG01[tapIdx] : 12'h000;
      mTap10 = (tapIdx >= lastReset) ? recG10[tapIdx] : 12'h000;
      mFlag  = forceG1 ? 1'b1 : (forceG10 ? 1'b0 : mSel);
      expOut = {mFlag, (mFlag ? mTap01 : mTap10)};
      expWin = mSel;
      recG01[t] = DATA_gain_01;
      recG10[t] = DATA_gain_10;
    end
    #1;
    outLog[t] = DATA_gain_sel;
    winLog[t] = win_active;
    checkOutput("cycleOut", 32'(DATA_gain_sel), 32'(expOut));
    checkOutput("cycleWin", 32'(win_active), 32'(expWin));
    checkOutput("seuError", 32'(SeuError), 32'h0);
  end

  task automatic resetDut();
    rst = 1'b1;
    repeat (3) @(negedge CLK);
    rst = 1'b0;
  endtask

  // Sample k reaches the DUT at edge base+k; its output appears at edge base+k+6.
  task automatic applyStimulus(input int n, input int satA, input int satB, input bit tw,
                               input bit f1, input bit f10, input bit ramp, output int base);
    resetDut();
    base        = t + 1;
    TIME_WINDOW = tw;
    forceG1     = f1;
    forceG10    = f10;
    for (int k = 0; k < n; k++) begin
      if (ramp) begin
        DATA_gain_10 = 12'(k);
        DATA_gain_01 = 12'h800 + 12'(k);
      end else begin
        DATA_gain_10 = (k == satA || k == satB) ? 12'hFFF : 12'h100;
        DATA_gain_01 = 12'h040 + 12'(k);
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    int base;
    int base2;
    rst = 1'b1;
    DATA_gain_01 = '0;
    DATA_gain_10 = '0;
    SATURATION_value = 12'hFFF;
    TIME_WINDOW = 1'b0;
    forceG1 = 1'b0;
    forceG10 = 1'b0;
    @(negedge CLK);

    applyStimulus(20, -1, -1, 1'b0, 1'b0, 1'b0, 1'b1, base);
    checkOutput("pipeInReset", 32'(outLog[base-1]), 32'h0);
    checkOutput("pipeZeroFill", 32'(outLog[base+5]), 32'h0);
    checkOutput("pipeSample0", 32'(outLog[base+6]), 32'h0);
    checkOutput("pipeSample1", 32'(outLog[base+7]), 32'h1);
    checkOutput("pipeSample10", 32'(outLog[base+16]), 32'h00A);
    checkOutput("pipeWin", 32'(winLog[base+16]), 32'h0);

    SATURATION_value = 12'hF00;
    applyStimulus(40, 20, -1, 1'b0, 1'b0, 1'b0, 1'b0, base);
    checkOutput("w8Sample14", 32'(outLog[base+20]), 32'h0100);
    checkOutput("w8Sample15", 32'(outLog[base+21]), 32'h104F);
    checkOutput("w8Sample22", 32'(outLog[base+28]), 32'h1056);
    checkOutput("w8Sample23", 32'(outLog[base+29]), 32'h0100);

    applyStimulus(40, 20, -1, 1'b1, 1'b0, 1'b0, 1'b0, base);
    checkOutput("w16Sample30", 32'(outLog[base+36]), 32'h105E);
    checkOutput("w16Sample31", 32'(outLog[base+37]), 32'h0100);

    applyStimulus(40, 20, 25, 1'b0, 1'b0, 1'b0, 1'b0, base);
    checkOutput("retrigSample23", 32'(outLog[base+29]), 32'h1057);
    checkOutput("retrigSample27", 32'(outLog[base+33]), 32'h105B);
    checkOutput("retrigSample28", 32'(outLog[base+34]), 32'h0100);

    applyStimulus(30, -1, -1, 1'b0, 1'b1, 1'b0, 1'b0, base);
    checkOutput("forceG1", 32'(outLog[base+16]), 32'h104A);
    applyStimulus(30, -1, -1, 1'b0, 1'b1, 1'b1, 1'b0, base);
    checkOutput("forceBoth", 32'(outLog[base+16]), 32'h104A);
    applyStimulus(40, 20, -1, 1'b0, 1'b0, 1'b1, 1'b0, base);
    checkOutput("forceG10Out", 32'(outLog[base+21]), 32'h0100);
    checkOutput("forceG10Win15", 32'(winLog[base+21]), 32'h1);
    checkOutput("forceG10Win22", 32'(winLog[base+28]), 32'h1);
    checkOutput("forceG10Win23", 32'(winLog[base+29]), 32'h0);
    forceG10 = 1'b0;

    // Abort an active window with an asynchronous reset right after sample 17 is output.
    applyStimulus(24, 20, -1, 1'b0, 1'b0, 1'b0, 1'b0, base);
    checkOutput("midWinSample17", 32'(outLog[base+23]), 32'h1051);
    rst = 1'b1;
    #1;
    checkOutput("asyncRstOut", 32'(DATA_gain_sel), 32'h0);
    checkOutput("asyncRstWin", 32'(win_active), 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    rst = 1'b0;
    base2 = t + 1;
    for (int k = 0; k < 12; k++) begin
      DATA_gain_10 = 12'h100;
      DATA_gain_01 = 12'h040 + 12'(k);
      @(negedge CLK);
    end
    for (int k = 0; k < 6; k++) begin
      checkOutput("postRstZero", 32'(outLog[base2+k]), 32'h0);
      checkOutput("postRstWin", 32'(winLog[base2+k]), 32'h0);
    end
    checkOutput("postRstResume", 32'(outLog[base2+6]), 32'h0100);

    // Random traffic: quasi-static threshold, occasional window-size change, forces and resets.
    for (int i = 0; i < 2000; i++) begin
      if (i % 250 == 0)
        SATURATION_value = ($urandom_range(0, 7) == 0) ? 12'h000 : 12'($urandom_range(12'h800, 12'hFFF));
      if ($urandom_range(0, 31) == 0) TIME_WINDOW = ~TIME_WINDOW;
      forceG1  = ($urandom_range(0, 15) == 0);
      forceG10 = ($urandom_range(0, 7) == 0);
      DATA_gain_10 = ($urandom_range(0, 19) == 0) ? 12'($urandom_range(12'hE00, 12'hFFF))
                                                  : 12'($urandom_range(0, 12'hDFF));
      DATA_gain_01 = 12'($urandom());
      rst = ($urandom_range(0, 299) == 0);
      @(negedge CLK);
    end
    rst = 1'b0;
    repeat (10) @(negedge CLK);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
